cla_pipelined_addsub: RTL and testbench
=======================================

# cla_pipelined_addsub

Parametrised, segmented pipelined adder/subtractor: the next generation of the team's pipelined carry-lookahead adder. Width W is split into S equal segments, with one segment resolved per pipeline stage and the carry passed between stages in a register. Over the current adder it adds:
- add/subtract mode;
- carry/borrow-in for multi-word chaining;
- carry-out and signed-overflow flags;
- a full valid/ready handshake with backpressure.

It sits between operand producers and the ALU result mux in the datapath.

## Interface
- W, 128: operand/result width; W % S must be 0 (elaboration error otherwise).
- S, 4: stage count = segment count; 1 ≤ S ≤ W; segment width SW = W/S.
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- op1  in  W  operand A.
- op2  in  W  operand B.
- sub  in  1  0 = add, 1 = subtract; sampled with operands.
- cin  in  1  carry-in (add) / borrow-in (sub); sampled with operands.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- res  out  W  result.
- cout  out  1  carry-out of bit W-1 (for subtract: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- out_valid  out  1  res/cout/ovf valid.
- out_ready  in  1  consumer accepts this cycle.

## Operation
- Arithmetic: B' = sub ? ~op2 : op2; c0 = cin ^ sub; {cout, res} = op1 + B' + c0, computed as a W+1-bit sum.
  - Add computes op1+op2+cin.
  - Sub computes op1−op2−cin.
- ovf = (op1[W-1] == B'[W-1]) && (res[W-1] != op1[W-1]), equivalently the carry into bit W-1 XOR cout.
- Stage k (0..S-1) adds segment k, bits [k·SW +: SW], of op1 and B' plus the registered carry from stage k-1 (c0 for stage 0). It registers:
  - the sum segment and the segment carry-out;
  - the valid bit;
  - all previously completed segments;
  - the not-yet-used operand segments, including the MSB bits needed for ovf.
- Stage S-1 registers drive res/cout/ovf/out_valid directly. There is no extra output register.
- Handshake: a global advance enable is en = ~out_valid | out_ready; in_ready = en.
  - When en = 1, every stage loads from its predecessor and stage 0 loads the input; stage 0 valid = in_valid.
  - When en = 0, all stage registers hold, including data, carries and valid bits.
  - A transfer in occurs on in_valid & in_ready; a transfer out occurs on out_valid & out_ready.
  - Bubbles (invalid stages) propagate as valid=0. Data content of invalid stages is don't-care but must never produce out_valid=1.
- Ordering is strictly FIFO; there is no drop and no duplication.
- Reset (rstn=0, asynchronous): all stage valid bits = 0, carries = 0, data = 0. Outputs: res=0, cout=0, ovf=0, out_valid=0, and in_ready=1 (combinational from out_valid=0).
  - Reset mid-operation discards all in-flight results.
  - Release is synchronous-safe: the first accept is possible on the first rising edge after rstn rises.
- S=1: a single registered W-bit add with the same handshake.

## Timing
- Latency: an operand accepted on edge t appears with out_valid=1 after edge t+S-1 (S register stages), provided no stall occurs.
- Throughput: one result per cycle while out_ready=1.
- A stall of n cycles (out_valid=1 & out_ready=0) adds exactly n cycles to every in-flight result.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid or operands to any output.
- Critical path is one SW-bit add plus the carry mux per stage.
- Simultaneous in/out transfer in the same cycle (pipeline full, out_ready=1) is legal and sustains the full rate.

## Test plan
- W=8, S=4, add: op1=0x7F, op2=0x01, cin=0, sub=0, single transaction -> after 4 edges res=0x80, cout=0, ovf=1, out_valid=1 for exactly one cycle with out_ready=1.
- W=8, S=4, sub: 0x00−0x01 (cin=0) -> res=0xFF, cout=0, ovf=0. Then 0x80−0x01 -> res=0x7F, cout=1, ovf=1. Then 0x05−0x03 with cin=1 -> res=0x01, cout=1.
- Carry ripple across all segments: W=8, S=4, 0xFF+0x00 with cin=1 -> res=0x00, cout=1, ovf=0. Repeat with W=128, S=4: all-ones + 1 -> res=0, cout=1.
- Backpressure: stream 6 back-to-back adds (i+0x10 for i=0..5) and hold out_ready=0 for 3 cycles once out_valid rises:
  - in_ready must be 0 during the stall;
  - res must hold;
  - all 6 results 0x10..0x15 must appear in order, with none lost or duplicated.
- Bubbles: in_valid toggled 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by S cycles, with correct sums.
- Reset mid-flight: accept 3 ops, assert rstn=0 asynchronously between edges -> out_valid, res, cout, ovf go to 0 immediately. After release, no stale result ever appears and a new op returns after S edges.
- Randomised sweep (W=128 with S∈{1,2,4,8}; W=12 with S=3): random ops, modes, cin and out_ready against a W+1-bit reference model, checking res, cout and ovf.

Source files
------------

// File: rtl/cla_pipelined_addsub.sv
// Segmented pipelined adder/subtractor: one SW-bit segment resolved per stage,
// with the carry handed forward in a register and a valid/ready handshake.
module cla_pipelined_addsub #(
    parameter int W = 128,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         sub,
    input  logic         cin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] res,
    output logic         cout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int SW = W / S;

    if (S < 1 || S > W || (W % S) != 0) begin : g_param_check
        $error("cla_pipelined_addsub: W must be a multiple of S and 1 <= S <= W");
    end

    // Each stage carries the full-width operands so later segments and the
    // MSBs needed for overflow travel with their transaction.
    typedef struct packed {
        logic         vld;
        logic         cy;
        logic [W-1:0] sum;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } stage_t;

    logic   en;
    stage_t last_q;

    for (genvar k = 0; k < S; k++) begin : g_stage
        stage_t      prev;
        stage_t      stage_d;
        stage_t      stage_q;
        logic [SW:0] seg_sum;

        if (k == 0) begin : g_in
            always_comb begin
                prev     = '0;
                prev.vld = in_valid;
                prev.cy  = cin ^ sub;
                prev.a   = op1;
                prev.b   = sub ? ~op2 : op2;
            end
        end else begin : g_chain
            assign prev = g_stage[k-1].stage_q;
        end

        assign seg_sum = {1'b0, prev.a[k*SW +: SW]}
                       + {1'b0, prev.b[k*SW +: SW]}
                       + {{SW{1'b0}}, prev.cy};

        always_comb begin
            stage_d                   = prev;
            stage_d.cy                = seg_sum[SW];
            stage_d.sum[k*SW +: SW]   = seg_sum[SW-1:0];
        end

        // NOTE: non-blocking assignments keep every stage sampling its
        // predecessor's pre-edge value; blocking here would collapse the pipe.
        // NOTE: data is reset along with valid so res/cout/ovf read 0 in reset,
        // which the downstream mux relies on.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stage_q <= '0;
            end else if (en) begin
                stage_q <= stage_d;
            end
        end
    end

    assign last_q    = g_stage[S-1].stage_q;

    // One global enable: any stall at the output freezes the whole pipe.
    assign en        = ~last_q.vld | out_ready;
    assign in_ready  = en;

    assign out_valid = last_q.vld;
    assign res       = last_q.sum;
    assign cout      = last_q.cy;
    assign ovf       = (last_q.a[W-1] == last_q.b[W-1]) && (last_q.sum[W-1] != last_q.a[W-1]);

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Self-checking bench: directed 8-bit vectors and corner sequences, plus a
// random sweep over several W/S configurations against a W+1-bit reference.
module tb_cla_pipelined_addsub;
    localparam int S8 = 4;
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 8-bit, 4-stage directed DUT
    logic [7:0] a8, b8, res8;
    logic       sub8, cin8, iv8, ordy8, ir8, cout8, ovf8, ov8;

    cla_pipelined_addsub #(.W(8), .S(S8)) dut8 (
        .clk(clk), .rstn(rstn), .op1(a8), .op2(b8), .sub(sub8), .cin(cin8),
        .in_valid(iv8), .in_ready(ir8), .res(res8), .cout(cout8), .ovf(ovf8),
        .out_valid(ov8), .out_ready(ordy8)
    );

    // Sweep instances: 0..3 are W=128 with S=1,2,4,8; 4 is W=12, S=3
    logic [NI-1:0][127:0] w_op1, w_op2;
    logic [NI-1:0]        w_sub, w_cin, w_iv, w_or;
    wire  [NI-1:0][127:0] w_res;
    wire  [NI-1:0]        w_ir, w_cout, w_ovf, w_ov;
    wire  [11:0]          res12;

    for (genvar g = 0; g < 4; g++) begin : g_wide
        cla_pipelined_addsub #(.W(128), .S(1 << g)) dut (
            .clk(clk), .rstn(rstn), .op1(w_op1[g]), .op2(w_op2[g]), .sub(w_sub[g]),
            .cin(w_cin[g]), .in_valid(w_iv[g]), .in_ready(w_ir[g]), .res(w_res[g]),
            .cout(w_cout[g]), .ovf(w_ovf[g]), .out_valid(w_ov[g]), .out_ready(w_or[g])
        );
    end

    cla_pipelined_addsub #(.W(12), .S(3)) dut12 (
        .clk(clk), .rstn(rstn), .op1(w_op1[4][11:0]), .op2(w_op2[4][11:0]), .sub(w_sub[4]),
        .cin(w_cin[4]), .in_valid(w_iv[4]), .in_ready(w_ir[4]), .res(res12),
        .cout(w_cout[4]), .ovf(w_ovf[4]), .out_valid(w_ov[4]), .out_ready(w_or[4])
    );
    assign w_res[4] = {116'd0, res12};

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    logic [129:0] sb [NI][32];
    int           hd [NI];
    int           tl [NI];

    int   sent, recv, stall, lat;
    logic seen;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {ovf, cout, res} from a w+1-bit sum of op1 + B' + c0
    function automatic logic [129:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input logic sub, input logic cin, input int w);
        logic [128:0] mask, aa, bx, s;
        logic         cy, ov;
        mask = (129'd1 << w) - 129'd1;
        aa   = {1'b0, a} & mask;
        bx   = (sub ? {1'b0, ~b} : {1'b0, b}) & mask;
        s    = aa + bx + {128'd0, cin ^ sub};
        cy   = s[w];
        ov   = (aa[w-1] == bx[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, cy, s[127:0] & mask[127:0]};
    endfunction

    task automatic run_one(input vec_t v, input int idx);
        int l;
        @(negedge clk);
        a8 = v.a; b8 = v.b; sub8 = v.sub; cin8 = v.cin; iv8 = 1'b1; ordy8 = 1'b1;
        #1 check($sformatf("v%0d in_ready", idx), 130'(ir8), 130'(1'b1));
        @(negedge clk);
        iv8 = 1'b0;
        l = 0;
        while (!ov8 && l < 20) begin
            @(negedge clk);
            l++;
        end
        check($sformatf("v%0d latency", idx), 130'(l), 130'(S8 - 1));
        check($sformatf("v%0d res", idx), 130'(res8), 130'(v.res));
        check($sformatf("v%0d cout", idx), 130'(cout8), 130'(v.cout));
        check($sformatf("v%0d ovf", idx), 130'(ovf8), 130'(v.ovf));
        @(negedge clk);
        check($sformatf("v%0d single pulse", idx), 130'(ov8), 130'(1'b0));
    endtask

    task automatic sweep(input int cycles);
        logic         drain;
        logic [129:0] exp;
        for (int i = 0; i < NI; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        for (int c = 0; c < cycles + 40; c++) begin
            @(negedge clk);
            drain = (c >= cycles);
            for (int i = 0; i < NI; i++) begin
                w_iv[i]  = !drain && ($urandom_range(3) != 0);
                w_or[i]  = drain || ($urandom_range(3) != 0);
                w_op1[i] = {$urandom, $urandom, $urandom, $urandom};
                w_op2[i] = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(7) == 0) w_op1[i] = '1;
                if ($urandom_range(7) == 0) w_op2[i] = 128'(c & 3);
                w_sub[i] = 1'($urandom_range(1));
                w_cin[i] = 1'($urandom_range(1));
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                if (w_ov[i] && w_or[i]) begin
                    check($sformatf("w%0d result expected", i), 130'(hd[i] != tl[i]), 130'(1'b1));
                    if (hd[i] != tl[i]) begin
                        exp = sb[i][hd[i] % 32];
                        hd[i]++;
                        check($sformatf("w%0d res", i), 130'(w_res[i]), 130'(exp[127:0]));
                        check($sformatf("w%0d cout", i), 130'(w_cout[i]), 130'(exp[128]));
                        check($sformatf("w%0d ovf", i), 130'(w_ovf[i]), 130'(exp[129]));
                    end
                end
                if (w_iv[i] && w_ir[i]) begin
                    sb[i][tl[i] % 32] = model(w_op1[i], w_op2[i], w_sub[i], w_cin[i], (i == 4) ? 12 : 128);
                    tl[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++)
            check($sformatf("w%0d outstanding", i), 130'(tl[i] - hd[i]), 130'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          a      b      sub   cin   res    cout  ovf
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[6] = '{8'hC8, 8'h9C, 1'b0, 1'b0, 8'h64, 1'b1, 1'b1};
        vecs[7] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[9] = '{8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        rstn = 1'b0;
        a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0; iv8 = 1'b0; ordy8 = 1'b1;
        w_op1 = '0; w_op2 = '0; w_sub = '0; w_cin = '0; w_iv = '0; w_or = '1;

        #3;
        check("reset res", 130'(res8), 130'(0));
        check("reset cout", 130'(cout8), 130'(0));
        check("reset ovf", 130'(ovf8), 130'(0));
        check("reset out_valid", 130'(ov8), 130'(0));
        check("reset in_ready", 130'(ir8), 130'(1));
        @(negedge clk);
        #2 rstn = 1'b1;

        for (int i = 0; i < 10; i++) run_one(vecs[i], i);

        // All-ones + 1 rippling through every segment, for S = 1, 2, 4, 8
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            w_op1[g] = '1; w_op2[g] = 128'd1; w_sub[g] = 1'b0; w_cin[g] = 1'b0;
            w_iv[g] = 1'b1; w_or[g] = 1'b1;
            @(negedge clk);
            w_iv[g] = 1'b0;
            lat = 0;
            while (!w_ov[g] && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("ripple S%0d latency", 1 << g), 130'(lat), 130'((1 << g) - 1));
            check($sformatf("ripple S%0d res", 1 << g), 130'(w_res[g]), 130'(0));
            check($sformatf("ripple S%0d cout", 1 << g), 130'(w_cout[g]), 130'(1));
            check($sformatf("ripple S%0d ovf", 1 << g), 130'(w_ovf[g]), 130'(0));
        end

        // Backpressure: six back-to-back adds, 3-cycle stall once output appears
        sent = 0; recv = 0; stall = 0; seen = 1'b0;
        b8 = 8'h10; sub8 = 1'b0; cin8 = 1'b0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            if (!seen && ov8) begin
                seen  = 1'b1;
                stall = 3;
            end
            ordy8 = (stall == 0);
            iv8   = (sent < 6);
            a8    = 8'(sent);
            #1;
            if (stall > 0) begin
                check("bp in_ready during stall", 130'(ir8), 130'(0));
                check("bp out_valid during stall", 130'(ov8), 130'(1));
                check("bp res held", 130'(res8), 130'(8'(8'h10 + recv)));
                stall--;
            end
            if (ov8 && ordy8) begin
                check($sformatf("bp result %0d", recv), 130'(res8), 130'(8'(8'h10 + recv)));
                recv++;
            end
            if (iv8 && ir8) sent++;
        end
        iv8 = 1'b0; ordy8 = 1'b1;
        check("bp results received", 130'(recv), 130'(6));
        check("bp stall observed", 130'(seen), 130'(1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 check("bp no duplicate", 130'(ov8), 130'(0));
        end

        // Bubbles: in_valid 1,0,1,0 shows up on out_valid S cycles later
        for (int n = 0; n < S8 + 6; n++) begin
            int m;
            @(negedge clk);
            ordy8 = 1'b1;
            iv8   = (n < 4) && (n % 2 == 0);
            a8    = (n == 0) ? 8'h21 : 8'h40;
            b8    = (n == 0) ? 8'h12 : 8'h40;
            cin8  = (n == 2);
            sub8  = 1'b0;
            #1;
            m = n - S8;
            check($sformatf("bubble out_valid %0d", n), 130'(ov8), 130'(m >= 0 && m < 4 && m % 2 == 0));
            if (m == 0) check("bubble res 0", 130'(res8), 130'(8'h33));
            if (m == 2) check("bubble res 1", 130'(res8), 130'(8'h81));
        end
        iv8 = 1'b0; cin8 = 1'b0;

        // Reset mid-flight: three ops in the pipe, first at the output
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            iv8 = (n < 3);
            a8  = 8'(n + 1);
            b8  = 8'h20;
        end
        check("mid-flight out_valid", 130'(ov8), 130'(1));
        check("mid-flight res", 130'(res8), 130'(8'h21));
        #2 rstn = 1'b0;
        #1;
        check("async reset out_valid", 130'(ov8), 130'(0));
        check("async reset res", 130'(res8), 130'(0));
        check("async reset cout", 130'(cout8), 130'(0));
        check("async reset ovf", 130'(ovf8), 130'(0));
        check("async reset in_ready", 130'(ir8), 130'(1));
        @(negedge clk);
        #2 rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1 check("no stale result", 130'(ov8), 130'(0));
        end
        run_one(vecs[4], 100);

        sweep(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
